snoop_bus_arbiter: RTL and testbench

//  Shares one snooping coherence bus between N_CACHES MESI cache controllers.

---
 rtl/snoop_bus_arbiter.sv | 152 +++++++++++++++
 tb/tb_snoop_bus_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_bus_arbiter.sv
// Shares one snooping coherence bus between MESI cache controllers. Grants round-robin,
// broadcasts the winner's command, gathers snoop acks, and reads memory when no cache flushed.
module snoop_bus_arbiter #(
    parameter int unsigned N_CACHES = 4,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned SRC_W    = $clog2(N_CACHES)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CACHES-1:0]        req_valid,
    input  logic [2*N_CACHES-1:0]      req_cmd,
    input  logic [ADDR_W*N_CACHES-1:0] req_addr,
    output logic [N_CACHES-1:0]        grant,
    output logic                       bus_valid,
    output logic [1:0]                 bus_cmd,
    output logic [ADDR_W-1:0]          bus_addr,
    output logic [SRC_W-1:0]           bus_src,
    input  logic [N_CACHES-1:0]        snoop_ack,
    input  logic [N_CACHES-1:0]        snoop_shared,
    input  logic [N_CACHES-1:0]        snoop_flush,
    output logic                       mem_rd_req,
    input  logic                       mem_rd_ack,
    output logic [N_CACHES-1:0]        done_valid,
    output logic                       done_shared,
    output logic                       done_flush
);
    localparam logic [1:0] CMD_UPGR = 2'b11;

    typedef enum logic [1:0] {IDLE, SNOOP, MEM, DONE} stateT;

    stateT               state, stateNxt;
    logic [SRC_W-1:0]    rrPtr;
    logic [N_CACHES-1:0] ackAcc, sharedAcc, flushAcc;
    logic [N_CACHES-1:0] ackNow, sharedNow, flushNow;
    logic [N_CACHES-1:0] eligible, srcOneHot, otherMask, snoopGate;
    logic                winFound, allAcked;
    logic [SRC_W-1:0]    winIdx;
    logic [N_CACHES-1:0] grantNxt, doneValidNxt;
    logic                busValidNxt, memRdReqNxt, doneSharedNxt, doneFlushNxt;

    function automatic logic [SRC_W-1:0] wrapIdx(input logic [SRC_W-1:0] base, input int unsigned off);
        return SRC_W'((32'(base) + off) % N_CACHES);
    endfunction

    // A request with the illegal command 00 never competes.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_CACHES; i++) begin
            eligible[i] = req_valid[i] && (req_cmd[2*i +: 2] != 2'b00);
        end
    end

    always_comb begin
        winFound = 1'b0;
        winIdx   = rrPtr;
        for (int unsigned k = 0; k < N_CACHES; k++) begin
            if (!winFound && eligible[wrapIdx(rrPtr, k)]) begin
                winFound = 1'b1;
                winIdx   = wrapIdx(rrPtr, k);
            end
        end
    end

    // Snoop results of the current cycle count only in SNOOP and only from non-requesters.
    assign srcOneHot = N_CACHES'(1) << bus_src;
    assign otherMask = ~srcOneHot;
    assign snoopGate = {N_CACHES{state == SNOOP}} & snoop_ack & otherMask;
    assign ackNow    = ackAcc | snoopGate;
    assign sharedNow = sharedAcc | (snoopGate & snoop_shared);
    assign flushNow  = flushAcc | (snoopGate & snoop_flush);
    assign allAcked  = &(ackNow | srcOneHot);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        case (state)
            IDLE:    if (winFound) stateNxt = SNOOP;
            SNOOP:   if (allAcked) stateNxt = ((bus_cmd == CMD_UPGR) || (|flushNow)) ? DONE : MEM;
            MEM:     if (mem_rd_ack) stateNxt = DONE;
            DONE:    stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    always_comb begin
        grantNxt      = '0;
        busValidNxt   = 1'b0;
        memRdReqNxt   = 1'b0;
        doneValidNxt  = '0;
        doneSharedNxt = 1'b0;
        doneFlushNxt  = 1'b0;
        if (state == IDLE && winFound) begin
            grantNxt = N_CACHES'(1) << winIdx;
        end
        busValidNxt = (stateNxt == SNOOP);
        memRdReqNxt = (stateNxt == MEM);
        if (stateNxt == DONE) begin
            doneValidNxt  = srcOneHot;
            doneSharedNxt = |sharedNow;
            doneFlushNxt  = |flushNow;
        end
    end

    // Registered outputs, broadcast payload, accumulators and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant       <= '0;
            bus_valid   <= 1'b0;
            bus_cmd     <= 2'b00;
            bus_addr    <= '0;
            bus_src     <= '0;
            mem_rd_req  <= 1'b0;
            done_valid  <= '0;
            done_shared <= 1'b0;
            done_flush  <= 1'b0;
            rrPtr       <= '0;
            ackAcc      <= '0;
            sharedAcc   <= '0;
            flushAcc    <= '0;
        end else begin
            grant       <= grantNxt;
            bus_valid   <= busValidNxt;
            mem_rd_req  <= memRdReqNxt;
            done_valid  <= doneValidNxt;
            done_shared <= doneSharedNxt;
            done_flush  <= doneFlushNxt;
            if (state == IDLE && winFound) begin
                bus_cmd  <= req_cmd[32'(winIdx)*2 +: 2];
                bus_addr <= req_addr[ADDR_W*32'(winIdx) +: ADDR_W];
                bus_src  <= winIdx;
            end
            if (state == SNOOP) begin
                ackAcc    <= ackNow;
                sharedAcc <= sharedNow;
                flushAcc  <= flushNow;
            end
            if (state == DONE) begin
                rrPtr     <= wrapIdx(bus_src, 1);
                ackAcc    <= '0;
                sharedAcc <= '0;
                flushAcc  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Scoreboard bench for snoop_bus_arbiter: a transaction-level model predicts each grant and
// completion; a negedge monitor pops and compares whenever the DUT pulses grant or done.
module tb_snoop_bus_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned SW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [2*N-1:0]  req_cmd;
    logic [AW*N-1:0] req_addr;
    logic [N-1:0]    grant;
    logic            bus_valid;
    logic [1:0]      bus_cmd;
    logic [AW-1:0]   bus_addr;
    logic [SW-1:0]   bus_src;
    logic [N-1:0]    snoop_ack, snoop_shared, snoop_flush;
    logic            mem_rd_req, mem_rd_ack;
    logic [N-1:0]    done_valid;
    logic            done_shared, done_flush;

    logic [1:0]    reqCmdR  [N];
    logic [AW-1:0] reqAddrR [N];

    snoop_bus_arbiter #(.N_CACHES(N), .ADDR_W(AW), .SRC_W(SW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_cmd(req_cmd), .req_addr(req_addr),
        .grant(grant), .bus_valid(bus_valid), .bus_cmd(bus_cmd), .bus_addr(bus_addr), .bus_src(bus_src),
        .snoop_ack(snoop_ack), .snoop_shared(snoop_shared), .snoop_flush(snoop_flush),
        .mem_rd_req(mem_rd_req), .mem_rd_ack(mem_rd_ack),
        .done_valid(done_valid), .done_shared(done_shared), .done_flush(done_flush)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_cmd[2*i +: 2]   = reqCmdR[i];
            req_addr[AW*i +: AW] = reqAddrR[i];
        end
    end

    typedef struct { int idx; logic [1:0] cmd; logic [AW-1:0] addr; } grantExpT;
    typedef struct { int idx; bit shr; bit fl; bit mem; int lat; } doneExpT;

    grantExpT grantQ[$];
    doneExpT  doneQ[$];
    grantExpT gExp;
    doneExpT  dExp;
    int nCmp = 0, nFail = 0;
    int cyc = 0, grantCyc = 0;
    bit memSeen = 0;
    int mdlPtr = 0;

    int planDly[N];
    bit planShr[N];
    bit planFl[N];
    int planMemDly;
    bit planSelf;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic finishRun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    endtask

    // Monitor: every grant/done pulse is checked against the oldest prediction.
    always @(negedge clk) begin
        if (rst) begin
            memSeen = 0;
        end else begin
            if (mem_rd_req) memSeen = 1;
            if (grant != '0) begin
                if (grantQ.size() == 0) begin
                    check("grant_unexpected", 64'(grant), 64'(0));
                end else begin
                    gExp = grantQ.pop_front();
                    grantCyc = cyc;
                    check("grant_onehot", 64'(grant), 64'(1) << gExp.idx);
                    check("bus_valid_at_grant", 64'(bus_valid), 64'(1));
                    check("bus_cmd", 64'(bus_cmd), 64'(gExp.cmd));
                    check("bus_addr", 64'(bus_addr), 64'(gExp.addr));
                    check("bus_src", 64'(bus_src), 64'(gExp.idx));
                end
            end
            if (done_valid != '0) begin
                if (doneQ.size() == 0) begin
                    check("done_unexpected", 64'(done_valid), 64'(0));
                end else begin
                    dExp = doneQ.pop_front();
                    check("done_valid", 64'(done_valid), 64'(1) << dExp.idx);
                    check("done_shared", 64'(done_shared), 64'(dExp.shr));
                    check("done_flush", 64'(done_flush), 64'(dExp.fl));
                    check("mem_read_used", 64'(memSeen), 64'(dExp.mem));
                    check("done_latency", 64'(cyc - grantCyc), 64'(dExp.lat));
                    check("bus_valid_at_done", 64'(bus_valid), 64'(0));
                end
                memSeen = 0;
            end
        end
    end

    // Reference arbitration: first eligible requester at or after the pointer, wrapping.
    function automatic int mdlWinner();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (mdlPtr + k) % N;
            if (req_valid[i] && reqCmdR[i] != 2'b00) return i;
        end
        return -1;
    endfunction

    task automatic setReq(input int i, input logic [1:0] cmd, input logic [AW-1:0] addr);
        req_valid[i] = 1'b1;
        reqCmdR[i]   = cmd;
        reqAddrR[i]  = addr;
    endtask

    task automatic planClear();
        for (int i = 0; i < N; i++) begin
            planDly[i] = 0; planShr[i] = 0; planFl[i] = 0;
        end
        planMemDly = 0;
        planSelf   = 0;
    endtask

    task automatic planRandom();
        for (int i = 0; i < N; i++) begin
            planDly[i] = int'($urandom % 5);
            planShr[i] = 1'($urandom % 2);
            planFl[i]  = 0;
        end
        if ($urandom % 4 == 0) planFl[$urandom % N] = 1;
        planMemDly = int'($urandom % 4);
        planSelf   = 1'($urandom % 2);
    endtask

    task automatic topUp();
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && reqCmdR[i] == 2'b00 && ($urandom % 2 == 1))
                req_valid[i] = 1'b0;
            else if (!req_valid[i] && ($urandom % 2 == 1))
                setReq(i, ($urandom % 8 == 0) ? 2'b00 : 2'($urandom_range(1, 3)), $urandom & 32'hFFFF_FFC0);
        end
        if (mdlWinner() < 0) setReq(int'($urandom % N), 2'($urandom_range(1, 3)), $urandom & 32'hFFFF_FFC0);
    endtask

    task automatic waitGrant();
        int waitCnt;
        waitCnt = 0;
        do begin
            @(negedge clk);
            mem_rd_ack = 1'b0;
            waitCnt++;
        end while (grant == '0 && waitCnt < 10);
        if (grant == '0) begin
            nCmp++; nFail++;
            $display("FAIL grant_timeout: no grant after %0d cycles, want one", waitCnt);
            finishRun();
        end
        req_valid = req_valid & ~grant;
    endtask

    // One full transaction: predict, then play requester, snoopers and memory.
    task automatic runRound();
        int w, maxDly, memCnt, waitCnt;
        bit shr, fl, mem, acked, junkDone, seen;
        int hold[N];
        grantExpT ge;
        doneExpT de;
        w = mdlWinner();
        if (w < 0) begin
            nCmp++; nFail++;
            $display("FAIL round_setup: no eligible requester, want one");
            finishRun();
        end
        maxDly = 0; shr = 0; fl = 0;
        for (int i = 0; i < N; i++) begin
            if (i != w) begin
                if (planDly[i] > maxDly) maxDly = planDly[i];
                shr |= planShr[i];
                fl  |= planFl[i];
            end
        end
        for (int i = 0; i < N; i++) hold[i] = (planDly[i] < maxDly) ? int'($urandom % 2) : 0;
        mem = !(reqCmdR[w] == 2'b11 || fl);
        ge.idx = w; ge.cmd = reqCmdR[w]; ge.addr = reqAddrR[w];
        de.idx = w; de.shr = shr; de.fl = fl; de.mem = mem;
        de.lat = mem ? (maxDly + 2 + planMemDly) : (maxDly + 1);
        grantQ.push_back(ge);
        doneQ.push_back(de);
        mdlPtr = (w + 1) % N;

        mem_rd_ack = ($urandom % 4 == 0);
        waitGrant();

        for (int c = 0; c <= maxDly; c++) begin
            if (c > 0) @(negedge clk);
            snoop_ack = '0; snoop_shared = '0; snoop_flush = '0;
            for (int i = 0; i < N; i++) begin
                if (i != w && c >= planDly[i] && c <= planDly[i] + hold[i]) begin
                    snoop_ack[i] = 1'b1; snoop_shared[i] = planShr[i]; snoop_flush[i] = planFl[i];
                end
            end
            if (planSelf && c == 0) begin
                snoop_ack[w] = 1'b1; snoop_shared[w] = 1'b1; snoop_flush[w] = 1'b1;
            end
        end

        memCnt = 0; acked = 0; junkDone = 0; seen = 0; waitCnt = 0;
        while (!seen) begin
            @(negedge clk);
            waitCnt++;
            snoop_ack = '0; snoop_shared = '0; snoop_flush = '0;
            mem_rd_ack = 1'b0;
            if (done_valid != '0) begin
                seen = 1;
            end else if (waitCnt > 40) begin
                nCmp++; nFail++;
                $display("FAIL done_timeout: no done after %0d cycles, want one", waitCnt);
                finishRun();
                seen = 1;
            end else if (mem_rd_req && !acked) begin
                if (!junkDone) begin
                    snoop_ack = '1; snoop_shared = '1; snoop_flush = '1;
                    junkDone = 1;
                end
                if (memCnt == planMemDly) begin
                    mem_rd_ack = 1'b1; acked = 1;
                end else begin
                    memCnt++;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        for (int i = 0; i < N; i++) begin reqCmdR[i] = 2'b00; reqAddrR[i] = '0; end
        snoop_ack = '0; snoop_shared = '0; snoop_flush = '0;
        mem_rd_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", 64'(grant), 64'(0));
        check("rst_bus_valid", 64'(bus_valid), 64'(0));
        check("rst_bus_cmd", 64'(bus_cmd), 64'(0));
        check("rst_bus_addr", 64'(bus_addr), 64'(0));
        check("rst_mem_rd_req", 64'(mem_rd_req), 64'(0));
        check("rst_done_valid", 64'(done_valid), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Read miss served by memory after a 3-cycle delay.
        setReq(0, 2'b01, 32'h0000_1000);
        planClear(); planMemDly = 3;
        runRound();
        // Read-exclusive served by a flushing peer.
        setReq(2, 2'b10, 32'h0000_2000);
        planClear(); planFl[1] = 1;
        runRound();
        // Upgrade with a sharer, minimum latency.
        setReq(3, 2'b11, 32'h0000_3000);
        planClear(); planShr[0] = 1;
        runRound();
        // All four request continuously: rotation 0,1,2,3,0, then drain.
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < N; i++)
                if (!req_valid[i]) setReq(i, 2'($urandom_range(1, 3)), $urandom & 32'hFFFF_FFC0);
            planRandom();
            runRound();
        end
        while (req_valid != '0) begin
            planRandom();
            runRound();
        end
        // Staggered acks with a self-ack and a pending illegal-command requester.
        setReq(0, 2'b01, 32'h0000_6000);
        setReq(2, 2'b00, 32'h0000_6600);
        planClear();
        planDly[1] = 1; planDly[2] = 4; planDly[3] = 6;
        planSelf = 1; planMemDly = 1;
        runRound();

        for (int r = 0; r < 40; r++) begin
            topUp();
            planRandom();
            runRound();
        end

        // Drain, then leave the pointer at 3 before the reset test.
        for (int i = 0; i < N; i++) if (reqCmdR[i] == 2'b00) req_valid[i] = 1'b0;
        while (req_valid != '0) begin
            planRandom();
            runRound();
        end
        req_valid = '0;
        setReq(2, 2'b01, 32'h0000_7700);
        planClear();
        runRound();

        // Reset in the middle of SNOOP drops the transaction.
        setReq(1, 2'b01, 32'h0000_7000);
        ge_push: begin
            grantExpT ge;
            ge.idx = mdlWinner(); ge.cmd = 2'b01; ge.addr = 32'h0000_7000;
            grantQ.push_back(ge);
        end
        waitGrant();
        @(negedge clk);
        check("pre_rst_bus_valid", 64'(bus_valid), 64'(1));
        rst = 1'b1;
        #1;
        check("midrst_grant", 64'(grant), 64'(0));
        check("midrst_bus_valid", 64'(bus_valid), 64'(0));
        check("midrst_bus_src", 64'(bus_src), 64'(0));
        check("midrst_mem_rd_req", 64'(mem_rd_req), 64'(0));
        check("midrst_done_valid", 64'(done_valid), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mdlPtr = 0;
        repeat (6) begin
            @(negedge clk);
            check("idle_grant", 64'(grant), 64'(0));
            check("idle_bus_valid", 64'(bus_valid), 64'(0));
        end
        // Pointer must restart at 0 after reset.
        setReq(3, 2'b10, 32'h0000_8300);
        setReq(0, 2'b01, 32'h0000_8000);
        planClear();
        runRound();
        planClear(); planMemDly = 2;
        runRound();
        repeat (3) @(negedge clk);
        check("queue_grant_empty", 64'(grantQ.size()), 64'(0));
        check("queue_done_empty", 64'(doneQ.size()), 64'(0));
        finishRun();
    end
endmodule
